acc_module: RTL and testbench

ACC_MODULE -- requirements
Module: acc_module

---
 rtl/acc_pkg.sv | 5 +
 rtl/acc_reg.sv | 41 ++++
 rtl/acc_module.sv | 50 +++++
 tb/tb_acc_module.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared width and data type for the FIR accumulator slice.
package acc_pkg;
    localparam int ACC_W = 21;
    typedef logic [ACC_W-1:0] acc_t;
endpackage

// File: rtl/acc_reg.sv
// Generic WIDTH-bit register: synchronous active-low reset, then clear, then load-enable.
module acc_reg
    import acc_pkg::*;
#(
    parameter int WIDTH = ACC_W
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Next-state selection: clear beats load, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = {WIDTH{1'b0}};
        end else if (en_i) begin
            q_d = d_i;
        end else begin
            q_d = q_q;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            q_q <= {WIDTH{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/acc_module.sv
// FIR accumulator: holds the running sum and captures the finished sample on store.
// Optional macro ACC_AUTO_CLR_EN: a store also clears the accumulator in the same cycle.
module acc_module
    import acc_pkg::*;
#(
    parameter int WIDTH = ACC_W
) (
    input  logic             clk_b,
    input  logic             rst_n,
    input  logic             FSM_Acc_en,
    input  logic             FSM_Acc_zapis,
    input  logic             FSM_reset_Acc,
    input  logic [WIDTH-1:0] suma_wynik,
    output logic [WIDTH-1:0] Acc_out,
    output logic [WIDTH-1:0] FIR_probka_wynik
);

    logic acc_clr_s;

`ifdef ACC_AUTO_CLR_EN
    // Clear dominates load, so FSM_Acc_en is ignored on a store cycle.
    assign acc_clr_s = FSM_reset_Acc | FSM_Acc_zapis;
`else
    assign acc_clr_s = FSM_reset_Acc;
`endif

    acc_reg #(
        .WIDTH (WIDTH)
    ) u_acc_reg (
        .clk_i   (clk_b),
        .rst_n_i (rst_n),
        .clr_i   (acc_clr_s),
        .en_i    (FSM_Acc_en),
        .d_i     (suma_wynik),
        .q_o     (Acc_out)
    );

    // Samples the pre-edge accumulator; the accumulator clear never reaches it.
    acc_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk_i   (clk_b),
        .rst_n_i (rst_n),
        .clr_i   (1'b0),
        .en_i    (FSM_Acc_zapis),
        .d_i     (Acc_out),
        .q_o     (FIR_probka_wynik)
    );

endmodule

// File: tb/tb_acc_module.sv
// Directed bench for acc_module; expectations follow ACC_AUTO_CLR_EN when defined.
module tb_acc_module;
    import acc_pkg::*;

    logic clk_b;
    logic rst_n;
    logic FSM_Acc_en;
    logic FSM_Acc_zapis;
    logic FSM_reset_Acc;
    acc_t suma_wynik;
    acc_t Acc_out;
    acc_t FIR_probka_wynik;

    int n_checks;
    int n_pass;

    acc_module #(
        .WIDTH (ACC_W)
    ) dut (
        .clk_b            (clk_b),
        .rst_n            (rst_n),
        .FSM_Acc_en       (FSM_Acc_en),
        .FSM_Acc_zapis    (FSM_Acc_zapis),
        .FSM_reset_Acc    (FSM_reset_Acc),
        .suma_wynik       (suma_wynik),
        .Acc_out          (Acc_out),
        .FIR_probka_wynik (FIR_probka_wynik)
    );

    initial clk_b = 1'b0;
    always #5 clk_b = ~clk_b;

    task automatic check_val(input string tag, input acc_t obs, input acc_t exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%06h expected 0x%06h", tag, obs, exp_v);
        end
    endtask

    // Drive inputs on the falling edge, let one rising edge pass, return on the next falling edge.
    task automatic cyc(input logic rst_v, input logic en_v, input logic zap_v,
                       input logic clr_v, input acc_t sum_v);
        rst_n         = rst_v;
        FSM_Acc_en    = en_v;
        FSM_Acc_zapis = zap_v;
        FSM_reset_Acc = clr_v;
        suma_wynik    = sum_v;
        @(posedge clk_b);
        @(negedge clk_b);
    endtask

    task automatic check_both(input string tag, input acc_t exp_acc, input acc_t exp_fir);
        check_val({tag, "_acc"}, Acc_out, exp_acc);
        check_val({tag, "_fir"}, FIR_probka_wynik, exp_fir);
    endtask

    acc_t acc_after_store;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0; FSM_Acc_en = 1'b0; FSM_Acc_zapis = 1'b0; FSM_reset_Acc = 1'b0;
        suma_wynik = 21'd0;
        @(negedge clk_b);

        // Reset for two cycles, then release
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 21'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 21'd0);
        check_both("reset", 21'd0, 21'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 21'd0);
        check_both("post_reset_idle", 21'd0, 21'd0);

        // Clear pulse, then load sequence 5..8
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 21'd0);
        check_val("clr_pulse_acc", Acc_out, 21'd0);
        for (int i = 5; i <= 8; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, acc_t'(i));
            check_val($sformatf("load_%0d", i), Acc_out, acc_t'(i));
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 21'd99);
        check_val("hold_8_a", Acc_out, 21'd8);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 21'd55);
        check_both("hold_8_b", 21'd8, 21'd0);

        // Store 8; auto-clear zeroes the accumulator on the same edge
`ifdef ACC_AUTO_CLR_EN
        acc_after_store = 21'd0;
`else
        acc_after_store = 21'd8;
`endif
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 21'd0);
        check_both("store_8", acc_after_store, 21'd8);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 21'd0);
        check_both("clr_keeps_fir", 21'd0, 21'd8);

        // Clear beats enable
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 21'd9);
        check_val("clr_over_en", Acc_out, 21'd0);

        // Store and load together: output gets old value 3
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 21'd3);
        check_val("load_3", Acc_out, 21'd3);
`ifdef ACC_AUTO_CLR_EN
        acc_after_store = 21'd0;
`else
        acc_after_store = 21'd4;
`endif
        cyc(1'b1, 1'b1, 1'b1, 0, 21'd4);
        check_both("store_and_load", acc_after_store, 21'd3);

        // Store with clear in the same cycle: output gets pre-edge value
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 21'd12);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 21'd0);
        check_both("store_and_clr", 21'd0, 21'd12);

        // Full-width value
`ifdef ACC_AUTO_CLR_EN
        acc_after_store = 21'd0;
`else
        acc_after_store = 21'h1FFFFF;
`endif
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 21'h1FFFFF);
        check_val("load_max", Acc_out, 21'h1FFFFF);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 21'd0);
        check_both("store_max", acc_after_store, 21'h1FFFFF);

        // Reset mid-run overrides enable/store/clear
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 21'd7);
        check_val("load_7", Acc_out, 21'd7);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 21'd9);
        check_both("reset_mid_run", 21'd0, 21'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 21'd2);
        check_both("first_after_reset", 21'd2, 21'd0);

        // Store alone of value 8
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 21'd8);
`ifdef ACC_AUTO_CLR_EN
        acc_after_store = 21'd0;
`else
        acc_after_store = 21'd8;
`endif
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 21'd0);
        check_both("store_8_again", acc_after_store, 21'd8);

        // Reset with all controls active
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 21'h0ABCDE);
        check_both("reset_all_active", 21'd0, 21'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
